mem_port_arbiter: RTL and testbench

Shares one single-ported, wait-stated 16-bit unified memory between the pipeline's instruction-fetch port (IF stage) and data port (MEM stage). It grants one access at a time, holds address and data stable across a req/ack memory handshake, and returns read data with a one-cycle valid pulse. It produces per-port stall signals that freeze the pipeline while an access is outstanding. A starvation counter keeps fetch from being locked out by back-to-back data accesses.

---
 rtl/mem_port_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single-ported, wait-stated memory.
// Data port has priority, bounded by a starvation counter that eventually lets fetch in.
module mem_port_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int STARVE_MAX  = 3,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              dm_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              bus_err
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, RESP} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } acc_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [7:0] WAIT_LIM   = 8'(ACK_TIMEOUT - 1);

  state_t     state;
  logic [3:0] starve_cnt;
  logic [7:0] wait_cnt;
  logic       grant_dm;
  logic       grant_if;
  acc_t       win;

  assign if_stall = if_req & ~if_valid;
  assign dm_stall = dm_req & ~dm_valid;

  // Fetch only overtakes a pending data request once the streak limit is hit.
  always_comb begin
    grant_dm = dm_req & ~(if_req & (starve_cnt == STARVE_LIM));
    grant_if = if_req & ~grant_dm;
    if (grant_dm) win = '{we: dm_we, addr: dm_addr, wdata: dm_wdata};
    else          win = '{we: 1'b0, addr: if_addr, wdata: mem_wdata};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      if_valid   <= 1'b0;
      dm_valid   <= 1'b0;
      bus_err    <= 1'b0;
      starve_cnt <= '0;
      wait_cnt   <= '0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_dm || grant_if) begin
            {mem_we, mem_addr, mem_wdata} <= win;
            mem_req  <= 1'b1;
            wait_cnt <= '0;
            state    <= grant_dm ? BUSY_DM : BUSY_IF;
          end
          if (grant_dm && if_req && starve_cnt != STARVE_LIM)
            starve_cnt <= starve_cnt + 4'd1;
          else if (grant_if)
            starve_cnt <= '0;
        end
        BUSY_IF, BUSY_DM: begin
          wait_cnt <= wait_cnt + 8'd1;
          // A late ack on the final wait cycle still completes normally.
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= RESP;
            if (state == BUSY_IF) begin
              if_rdata <= mem_rdata;
              if_valid <= 1'b1;
            end else begin
              if (!mem_we) dm_rdata <= mem_rdata;
              dm_valid <= 1'b1;
            end
          end else if (wait_cnt == WAIT_LIM) begin
            mem_req <= 1'b0;
            state   <= RESP;
            bus_err <= 1'b1;
            if (state == BUSY_IF) begin
              if_rdata <= '0;
              if_valid <= 1'b1;
            end else begin
              if (!mem_we) dm_rdata <= '0;
              dm_valid <= 1'b1;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed timing/reset checks, then randomized traffic against a cycle-level
// arbitration + memory reference model with a queue-based response scoreboard.
module tb_mem_port_arbiter;
  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int SMAX = 3;
  localparam int TMO  = 8;
  localparam int NOACK = -1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0, mem_ack = 1'b0;
  logic [AW-1:0] if_addr = '0, dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0, mem_rdata = '0;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          if_valid, if_stall, dm_valid, dm_stall, mem_req, mem_we, bus_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX), .ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
  );

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  bit mon_en = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, got, exp, cyc);
  endtask

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            at;
  } exp_t;
  exp_t if_q[$], dm_q[$];

  // Reference memory: untouched words hold an address-derived pattern.
  logic [DW-1:0] mem_arr [int];
  function automatic logic [DW-1:0] mem_rd(input int a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return 16'(a * 291) ^ 16'h5A5A;
  endfunction

  // Monitor: stall relation every cycle, response pops on each valid pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      chk("if_stall", if_stall, if_req & ~if_valid);
      chk("dm_stall", dm_stall, dm_req & ~dm_valid);
      if (mon_en) begin
        if (if_valid) begin
          if (if_q.size() == 0) begin
            n_chk++;
            $display("FAIL if_valid_unexpected: got pulse, expected none (cycle %0d)", cyc);
          end else begin
            e = if_q.pop_front();
            chk("if_rdata", if_rdata, e.rdata);
            chk("if_bus_err", bus_err, e.err);
            chk("if_valid_cycle", cyc, e.at);
          end
        end
        if (dm_valid) begin
          if (dm_q.size() == 0) begin
            n_chk++;
            $display("FAIL dm_valid_unexpected: got pulse, expected none (cycle %0d)", cyc);
          end else begin
            e = dm_q.pop_front();
            chk("dm_rdata", dm_rdata, e.rdata);
            chk("dm_bus_err", bus_err, e.err);
            chk("dm_valid_cycle", cyc, e.at);
          end
        end
        if (!if_valid && !dm_valid) chk("bus_err_quiet", bus_err, 1'b0);
      end
    end
  end

  // Model state for the random phase.
  bit            busy = 0, cur_dm = 0, cur_we = 0;
  int            idle_from = 0, ack_cyc = 0, end_cyc = 0, streak = 0, d = 0, r = 0;
  logic [AW-1:0] cur_addr = '0;
  logic [DW-1:0] last_wdata = '0, last_dm = '0, v = '0;
  int            n_dm_grant = 0, n_if_grant = 0, n_starve = 0, n_tmo = 0;

  initial begin
    exp_t e;
    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_mem_req", mem_req, 1'b0);    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0); chk("rst_mem_wdata", mem_wdata, 16'h0);
    chk("rst_if_rdata", if_rdata, 16'h0); chk("rst_dm_rdata", dm_rdata, 16'h0);
    chk("rst_if_valid", if_valid, 1'b0);  chk("rst_dm_valid", dm_valid, 1'b0);
    chk("rst_bus_err", bus_err, 1'b0);
    rst_n = 1'b1;

    // Zero-wait fetch.
    @(posedge clk); #1 if_req = 1'b1; if_addr = 16'h0010;
    @(negedge clk); chk("zw_c0_mem_req", mem_req, 1'b0); chk("zw_c0_if_stall", if_stall, 1'b1);
    @(posedge clk); #1 mem_ack = 1'b1; mem_rdata = 16'hA123;
    @(negedge clk);
    chk("zw_c1_mem_req", mem_req, 1'b1); chk("zw_c1_mem_addr", mem_addr, 16'h0010);
    chk("zw_c1_mem_we", mem_we, 1'b0);   chk("zw_c1_if_stall", if_stall, 1'b1);
    @(posedge clk); #1 mem_ack = 1'b0; mem_rdata = 16'h0;
    @(negedge clk);
    chk("zw_c2_if_valid", if_valid, 1'b1); chk("zw_c2_if_rdata", if_rdata, 16'hA123);
    chk("zw_c2_mem_req", mem_req, 1'b0);
    @(posedge clk); #1 if_req = 1'b0;
    @(negedge clk); chk("zw_c3_if_valid", if_valid, 1'b0);

    // Reset in the middle of a fetch.
    @(posedge clk); #1 if_req = 1'b1; if_addr = 16'h0020;
    @(posedge clk); #1 chk("mr_busy_mem_req", mem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_mem_req", mem_req, 1'b0);   chk("mr_mem_addr", mem_addr, 16'h0);
    chk("mr_if_rdata", if_rdata, 16'h0); chk("mr_mem_we", mem_we, 1'b0);
    chk("mr_if_valid", if_valid, 1'b0); chk("mr_if_stall", if_stall, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mr_regrant_req", mem_req, 1'b1); chk("mr_regrant_addr", mem_addr, 16'h0020);
    mem_ack = 1'b1; mem_rdata = 16'h1357;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("mr_if_valid2", if_valid, 1'b1); chk("mr_if_rdata2", if_rdata, 16'h1357);
    if_req = 1'b0;
    repeat (3) @(posedge clk);

    // Randomized traffic.
    mon_en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      cyc++;
      mem_ack = 1'b0;
      mem_rdata = 16'($urandom);

      if (!busy) begin
        if (cyc - 1 >= idle_from && (if_req || dm_req)) begin
          cur_dm = dm_req && !(if_req && streak == SMAX);
          if (cur_dm) begin
            if (if_req) streak = (streak < SMAX) ? streak + 1 : SMAX;
            cur_we = dm_we; cur_addr = dm_addr; last_wdata = dm_wdata;
            n_dm_grant++;
          end else begin
            if (dm_req) n_starve++;
            streak = 0;
            cur_we = 1'b0; cur_addr = if_addr;
            n_if_grant++;
          end
          busy = 1;
          r = $urandom_range(0, 19);
          d = (r < 2) ? NOACK : (r < 10) ? 0 : ((r - 10 > 7) ? 7 : r - 10);
          if (d == NOACK) begin
            n_tmo++;
            end_cyc = cyc + TMO;
            e.err = 1'b1; e.at = end_cyc;
            if (cur_dm) begin
              if (!cur_we) last_dm = '0;
              e.rdata = last_dm; dm_q.push_back(e);
            end else begin
              e.rdata = '0; if_q.push_back(e);
            end
          end else begin
            ack_cyc = cyc + d;
            end_cyc = ack_cyc + 1;
          end
          idle_from = end_cyc + 1;
        end else begin
          chk("idle_mem_req", mem_req, 1'b0);
        end
      end

      if (busy) begin
        if (cyc < end_cyc) begin
          chk("busy_mem_req", mem_req, 1'b1);
          chk("busy_mem_addr", mem_addr, cur_addr);
          chk("busy_mem_we", mem_we, cur_we);
          chk("busy_mem_wdata", mem_wdata, last_wdata);
          if (d != NOACK && cyc == ack_cyc) begin
            mem_ack = 1'b1;
            e.err = 1'b0; e.at = end_cyc;
            if (cur_dm && cur_we) begin
              mem_arr[int'(cur_addr)] = last_wdata;
              e.rdata = last_dm; dm_q.push_back(e);
            end else begin
              v = mem_rd(int'(cur_addr));
              mem_rdata = v; e.rdata = v;
              if (cur_dm) begin last_dm = v; dm_q.push_back(e); end
              else if_q.push_back(e);
            end
          end
        end else begin
          chk("resp_mem_req", mem_req, 1'b0);
          busy = 0;
        end
      end

      // Stray acks outside BUSY must be ignored.
      if (!busy && $urandom_range(0, 7) == 0) mem_ack = 1'b1;

      if (if_req) begin
        if (if_valid) if_req = 1'b0;
      end else if (i < 3800 && $urandom_range(0, 99) < 40) begin
        if_req = 1'b1; if_addr = 16'($urandom_range(0, 15));
      end
      if (dm_req) begin
        if (dm_valid) dm_req = 1'b0;
      end else if (i < 3800 && $urandom_range(0, 99) < 75) begin
        dm_req = 1'b1; dm_we = 1'($urandom_range(0, 1));
        dm_addr = 16'($urandom_range(0, 15)); dm_wdata = 16'($urandom);
      end
    end

    chk("if_q_drained", if_q.size(), 0);
    chk("dm_q_drained", dm_q.size(), 0);
    chk("model_idle_at_end", busy, 1'b0);
    $display("grants dm=%0d if=%0d starve_overrides=%0d timeouts=%0d",
             n_dm_grant, n_if_grant, n_starve, n_tmo);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
